// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared SHA-256 definitions. Contains the message padder state
//               encoding, the block and word geometry constants, and the
//               initial hash values H0..H7 used by SHA256_core.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int c_word_width      = 32;
  localparam int c_block_words     = 16;
  localparam int c_block_width     = c_word_width * c_block_words;
  localparam int c_len_field_width = 64;

  // A 0x80 marker byte in byte lane 0 and zeros elsewhere.
  localparam logic [c_word_width-1:0] c_pad_marker_word = 32'h8000_0000;

  // Padder states.
  typedef enum logic [1:0] {
    eFill     = 2'd0,
    eEmit     = 2'd1,
    eEmitLast = 2'd2
  } padder_state_e;

  // Initial hash values H0..H7, which the core reloads on a first block.
  localparam logic [c_word_width-1:0] c_h0 = 32'h6a09_e667;
  localparam logic [c_word_width-1:0] c_h1 = 32'hbb67_ae85;
  localparam logic [c_word_width-1:0] c_h2 = 32'h3c6e_f372;
  localparam logic [c_word_width-1:0] c_h3 = 32'ha54f_f53a;
  localparam logic [c_word_width-1:0] c_h4 = 32'h510e_527f;
  localparam logic [c_word_width-1:0] c_h5 = 32'h9b05_688c;
  localparam logic [c_word_width-1:0] c_h6 = 32'h1f83_d9ab;
  localparam logic [c_word_width-1:0] c_h7 = 32'h5be0_cd19;

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pad_word
// Description : Combinational padding for the final message word. Keeps the
//               first i_nbytes bytes (byte 0 in [31:24]), writes 0x80 into
//               the byte that follows them and zeroes the rest of the word.
//               When all four bytes are valid the marker cannot fit and
//               o_overflow flags that it belongs at byte 0 of the next word.
// Ports       : i_word     - final message word, big-endian byte order
//               i_nbytes   - valid bytes in i_word, 0..4 (>4 treated as 4)
//               o_word     - masked word with the 0x80 marker inserted
//               o_overflow - marker did not fit in this word
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [c_word_width-1:0] i_word,
  input  logic [2:0]              i_nbytes,
  output logic [c_word_width-1:0] o_word,
  output logic                    o_overflow
);

  always_comb begin
    o_word = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < i_nbytes) begin
        o_word[31-8*j -: 8] = i_word[31-8*j -: 8];
      end else if (3'(j) == i_nbytes) begin
        o_word[31-8*j -: 8] = 8'h80;
      end
    end
  end

  assign o_overflow = (i_nbytes >= 3'd4);

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_padder
// Description : FIPS 180-4 message padder in front of SHA256_core. Collects
//               32-bit big-endian message words into a 16-word buffer, adds
//               the 0x80 marker, zero fill and the 64-bit message bit length,
//               and hands out 512-bit blocks tagged first/last.
// Parameters  : len_width_p  - width of the bit-length counter (<= 64),
//                              zero-extended into the 64-bit length field
// Ports       : clk_i, reset_n_i          - clock, async active-low reset
//               v_i, data_i, last_i,
//               last_bytes_i, ready_o     - word input handshake
//               v_o, ready_i, msg_o,
//               first_o, last_o           - block output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int len_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [c_word_width-1:0]  data_i,
  input  logic                     last_i,
  input  logic [2:0]               last_bytes_i,
  output logic                     ready_o,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [c_block_width-1:0] msg_o,
  output logic                     first_o,
  output logic                     last_o
);

  padder_state_e r_state;
  padder_state_e w_state_nxt;

  logic [c_word_width-1:0] r_buf [c_block_words];
  logic [4:0]              r_idx;
  logic [len_width_p-1:0]  r_len;
  logic                    r_extra_pending;
  logic                    r_extra_marker;
  logic                    r_first_pending;
  logic                    r_ready;
  logic                    r_v;
  logic                    r_first;
  logic                    r_last;

  logic                         w_in_xfer;
  logic                         w_out_xfer;
  logic [3:0]                   w_k;
  logic [2:0]                   w_nbytes;
  logic [c_word_width-1:0]      w_pad_word;
  logic                         w_overflow;
  logic [4:0]                   w_pad_ptr;
  logic [len_width_p-1:0]       w_len_last;
  logic [c_len_field_width-1:0] w_len_field_last;
  logic [c_len_field_width-1:0] w_len_field_cur;

  assign w_in_xfer  = v_i & r_ready;
  assign w_out_xfer = r_v & ready_i;
  assign w_k        = r_idx[3:0];
  assign w_nbytes   = (last_bytes_i > 3'd4) ? 3'd4 : last_bytes_i;

  sha256_pad_word u_pad_word (
    .i_word     (data_i),
    .i_nbytes   (w_nbytes),
    .o_word     (w_pad_word),
    .o_overflow (w_overflow)
  );

  // First free word after the final data word and its marker.
  assign w_pad_ptr        = w_overflow ? (r_idx + 5'd2) : (r_idx + 5'd1);
  assign w_len_last       = r_len + len_width_p'({w_nbytes, 3'b000});
  assign w_len_field_last = c_len_field_width'(w_len_last);
  assign w_len_field_cur  = c_len_field_width'(r_len);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      eFill: begin
        if (w_in_xfer) begin
          if (last_i) begin
            // Words 14/15 must be free for the length, otherwise a second
            // block carries it.
            w_state_nxt = (w_pad_ptr <= 5'd14) ? eEmitLast : eEmit;
          end else if (r_idx == 5'd15) begin
            w_state_nxt = eEmit;
          end
        end
      end
      eEmit: begin
        if (w_out_xfer) begin
          w_state_nxt = r_extra_pending ? eEmitLast : eFill;
        end
      end
      eEmitLast: begin
        if (w_out_xfer) begin
          w_state_nxt = eFill;
        end
      end
      default: w_state_nxt = eFill;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and registered handshake/tag outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= eFill;
      r_ready <= 1'b0;
      r_v     <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == eFill);
      r_v     <= (w_state_nxt != eFill);
      r_last  <= (w_state_nxt == eEmitLast);
      // The first tag is captured on leaving eFill; any block transfer
      // clears it so an overflow block of the same message is not tagged.
      if ((r_state == eFill) && (w_state_nxt != eFill)) begin
        r_first <= r_first_pending;
      end else if (w_out_xfer) begin
        r_first <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Block buffer, word index and length counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < c_block_words; i++) begin
        r_buf[i] <= '0;
      end
      r_idx           <= '0;
      r_len           <= '0;
      r_extra_pending <= 1'b0;
      r_extra_marker  <= 1'b0;
      r_first_pending <= 1'b1;
    end else if (w_in_xfer) begin
      if (last_i) begin
        r_buf[w_k] <= w_pad_word;
        if (w_overflow && (w_k != 4'd15)) begin
          r_buf[w_k + 4'd1] <= c_pad_marker_word;
        end
        // Remaining words are already zero because the buffer is cleared
        // on every block transfer.
        if (w_pad_ptr <= 5'd14) begin
          r_buf[4'd14] <= w_len_field_last[63:32];
          r_buf[4'd15] <= w_len_field_last[31:0];
        end
        r_len           <= w_len_last;
        r_extra_pending <= (w_pad_ptr > 5'd14);
        r_extra_marker  <= w_overflow && (w_k == 4'd15);
      end else begin
        r_buf[w_k] <= data_i;
        r_idx      <= r_idx + 5'd1;
        r_len      <= r_len + len_width_p'(32);
      end
    end else if (w_out_xfer) begin
      for (int i = 0; i < c_block_words; i++) begin
        r_buf[i] <= '0;
      end
      r_idx           <= '0;
      r_first_pending <= (r_state == eEmitLast);
      if ((r_state == eEmit) && r_extra_pending) begin
        // Length-only block; carries the marker when the last word filled
        // word 15 completely.
        r_buf[4'd0]     <= r_extra_marker ? c_pad_marker_word : '0;
        r_buf[4'd14]    <= w_len_field_cur[63:32];
        r_buf[4'd15]    <= w_len_field_cur[31:0];
        r_extra_pending <= 1'b0;
        r_extra_marker  <= 1'b0;
      end
      if (r_state == eEmitLast) begin
        r_len <= '0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < c_block_words; gi++) begin : g_pack
      assign msg_o[c_block_width-1-c_word_width*gi -: c_word_width] = r_buf[gi];
    end
  endgenerate

  assign ready_o = r_ready;
  assign v_o     = r_v;
  assign first_o = r_first;
  assign last_o  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_padder
// Description : Self-checking bench for sha256_msg_padder. A byte-level
//               padding model pushes expected blocks to a scoreboard queue as
//               each message is driven; a collector pops and compares them as
//               the DUT hands blocks out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic [31:0]  data_i;
  logic         last_i;
  logic [2:0]   last_bytes_i;
  logic         ready_o;
  logic         v_o;
  logic         ready_i;
  logic [511:0] msg_o;
  logic         first_o;
  logic         last_o;

  always #5 clk_i = ~clk_i;

  sha256_msg_padder #(.len_width_p(64)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .last_bytes_i (last_bytes_i),
    .ready_o      (ready_o),
    .v_o          (v_o),
    .ready_i      (ready_i),
    .msg_o        (msg_o),
    .first_o      (first_o),
    .last_o       (last_o)
  );

  typedef struct packed {
    logic [511:0] msg;
    logic         first;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  logic [7:0]  tx_bytes[$];
  bit          drv_done;
  int          n_pass;
  int          n_checks;

  // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    int          nblk;
    blk_t        e;
    p      = tx_bytes;
    bitlen = 64'(tx_bytes.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e = '0;
      for (int j = 0; j < 64; j++) e.msg[511-8*j -: 8] = p[64*b+j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_bytes(input int n, input bit rnd);
    tx_bytes = {};
    for (int i = 0; i < n; i++) tx_bytes.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  // Drives tx_bytes as words; starts and ends on a falling edge.
  task automatic drive_bytes(input bit send_last, input bit gaps);
    int n, nw, b, tmo;
    logic [31:0] word;
    n  = tx_bytes.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int j = 0; j < 4; j++) if (4*w + j < n) word[31-8*j -: 8] = tx_bytes[4*w+j];
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk_i);
      b = n - 4*w;
      if (b > 4) b = 4;
      v_i          = 1'b1;
      data_i       = word;
      last_i       = send_last && (w == nw - 1);
      last_bytes_i = 3'(b);
      tmo = 0;
      while (ready_o !== 1'b1 && tmo < 400) begin
        @(negedge clk_i);
        tmo++;
      end
      if (tmo >= 400) begin
        n_checks++;
        $display("FAIL drv_timeout ready_o=%b required 1", ready_o);
        v_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      v_i    = 1'b0;
      last_i = 1'b0;
    end
  endtask

  // Pops and compares blocks until the driver is done and the queue drains.
  task automatic collect(input int hold, input bit rnd);
    int   tmo;
    blk_t e;
    tmo = 0;
    while (!(drv_done && exp_q.size() == 0)) begin
      if (tmo > 2000) begin
        n_checks++;
        $display("FAIL col_timeout v_o=%b queued=%0d required delivery", v_o, exp_q.size());
        ready_i = 1'b0;
        return;
      end
      if (v_o === 1'b1 && hold > 0 && exp_q.size() > 0) begin
        ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk_i);
          n_checks++;
          if (msg_o !== exp_q[0].msg || v_o !== 1'b1 || ready_o !== 1'b0)
            $display("FAIL hold_stable cyc=%0d v_o=%b ready_o=%b msg_o=%h required v_o=1 ready_o=0 msg_o=%h",
                     h, v_o, ready_o, msg_o, exp_q[0].msg);
          else n_pass++;
        end
        hold = 0;
      end
      if (v_o === 1'b1) ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      else              ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v_o === 1'b1 && ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_block msg_o=%h required no block", msg_o);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (msg_o !== e.msg) $display("FAIL blk_msg msg_o=%h required %h", msg_o, e.msg);
          else n_pass++;
          n_checks++;
          if (first_o !== e.first) $display("FAIL blk_first first_o=%b required %b", first_o, e.first);
          else n_pass++;
          n_checks++;
          if (last_o !== e.last) $display("FAIL blk_last last_o=%b required %b", last_o, e.last);
          else n_pass++;
        end
        tmo = 0;
      end
      @(negedge clk_i);
      tmo++;
    end
    ready_i = 1'b0;
  endtask

  task automatic do_msg(input int hold, input bit rnd, input bit gaps);
    model_push();
    drv_done = 1'b0;
    fork
      begin
        drive_bytes(1'b1, gaps);
        drv_done = 1'b1;
      end
      collect(hold, rnd);
    join
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    v_i = 1'b0; data_i = '0; last_i = 1'b0; last_bytes_i = '0; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({v_o, ready_o, first_o, last_o} !== 4'b0000)
      $display("FAIL reset_flags v_o/ready_o/first_o/last_o=%b required 0000", {v_o, ready_o, first_o, last_o});
    else n_pass++;
    n_checks++;
    if (msg_o !== '0) $display("FAIL reset_msg msg_o=%h required 0", msg_o);
    else n_pass++;
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0)
      $display("FAIL post_reset ready_o=%b v_o=%b required ready_o=1 v_o=0", ready_o, v_o);
    else n_pass++;
  endtask

  task automatic test_abc();
    logic [511:0] lit;
    tx_bytes = '{8'h61, 8'h62, 8'h63};
    model_push();
    ready_i = 1'b0;
    drive_bytes(1'b1, 1'b0);
    // One cycle after the last word transfer the block must be presented.
    n_checks++;
    if (v_o !== 1'b1 || first_o !== 1'b1 || last_o !== 1'b1)
      $display("FAIL abc_latency v_o/first_o/last_o=%b required 111", {v_o, first_o, last_o});
    else n_pass++;
    lit = '0;
    lit[511:480] = 32'h6162_6380;
    lit[31:0]    = 32'h0000_0018;
    n_checks++;
    if (msg_o !== lit) $display("FAIL abc_literal msg_o=%h required %h", msg_o, lit);
    else n_pass++;
    drv_done = 1'b1;
    collect(0, 1'b0);
  endtask

  task automatic test_empty();
    tx_bytes = {};
    do_msg(0, 1'b0, 1'b0);
  endtask

  task automatic test_55_bytes();
    fill_bytes(55, 1'b0);
    do_msg(0, 1'b0, 1'b0);
  endtask

  task automatic test_56_bytes();
    fill_bytes(56, 1'b0);
    do_msg(0, 1'b1, 1'b0);
  endtask

  task automatic test_64_backpressure();
    fill_bytes(64, 1'b0);
    do_msg(5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill_bytes(28, 1'b1);
    ready_i  = 1'b1;
    drive_bytes(1'b0, 1'b0);
    reset_n_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || v_o !== 1'b0 || msg_o !== '0)
      $display("FAIL mid_reset ready_o=%b v_o=%b msg_o=%h required 0 0 0", ready_o, v_o, msg_o);
    else n_pass++;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1)
      $display("FAIL mid_reset_release v_o=%b ready_o=%b required v_o=0 ready_o=1", v_o, ready_o);
    else n_pass++;
    tx_bytes = '{8'h61, 8'h62, 8'h63};
    do_msg(0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int sizes[6] = '{60, 59, 10, 70, 0, 3};
    drv_done = 1'b0;
    fork
      begin
        for (int m = 0; m < 6; m++) begin
          fill_bytes(sizes[m], 1'b1);
          model_push();
          drive_bytes(1'b1, 1'b1);
        end
        drv_done = 1'b1;
      end
      collect(0, 1'b1);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass   = 0;
    n_checks = 0;
    drv_done = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_55_bytes();
    test_56_bytes();
    test_64_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
